// File: rtl/seg_shift_pkg.sv
// ============================================================================
// Module : seg_shift_pkg
// Brief  : Shared state encoding and chain-width helper for seg_shift_out.
//          Optional feature macro: SEG_SHIFT_DP_EN (8 bits per digit incl. dp)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_shift_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

`ifdef SEG_SHIFT_DP_EN
    localparam int c_digit_w = 8;
`else
    localparam int c_digit_w = 7;
`endif

    // Number of bits shifted onto the external chain per transfer.
    function automatic int seg_bits(input int num_digits);
        return num_digits * c_digit_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_shift_tick.sv
// ============================================================================
// Module : seg_shift_tick
// Brief  : Half-period divider; o_tick marks the last cycle of each CLK_DIV
//          cycle window, i_restart holds the window at its first cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_shift_tick
    import seg_shift_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int              c_cw   = $clog2(CLK_DIV + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(CLK_DIV - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    logic [c_cw-1:0] r_cnt;
    logic            w_tick;

    assign w_tick = (r_cnt == c_last);
    assign o_tick = w_tick;

    // Wrapping on tick means every state entry after a tick starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_shift_out.sv
// ============================================================================
// Module : seg_shift_out
// Brief  : Serialises all digit segment patterns MSB-first onto a 74HC595
//          chain (sclk/sdata) and pulses latch. Macro: SEG_SHIFT_DP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_shift_out
    import seg_shift_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7*NUM_DIGITS-1:0] seg_data,
`ifdef SEG_SHIFT_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp,
`endif
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    sclk,
    output logic                    sdata,
    output logic                    latch
);

    localparam int              c_bits = seg_bits(NUM_DIGITS);
    localparam int              c_bw   = $clog2(c_bits);
    localparam logic [c_bw-1:0] c_last = c_bw'(c_bits - 1);
    localparam logic [c_bw-1:0] c_one  = c_bw'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_bits-1:0] r_shift;
    logic [c_bits-1:0] w_shift_nxt;
    logic [c_bits-1:0] w_load;
    logic [c_bw-1:0]   r_bitcnt;
    logic [c_bw-1:0]   w_bitcnt_nxt;
    logic              w_done_nxt;
    logic              w_tick;
    logic              w_restart;

    logic              r_busy;
    logic              r_done;
    logic              r_sclk;
    logic              r_sdata;
    logic              r_latch;

    // Digit k's dp bit sits directly above its segment a, so it leaves first.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_pack
`ifdef SEG_SHIFT_DP_EN
        assign w_load[8*k +: 8] = {dp[k], seg_data[7*k +: 7]};
`else
        assign w_load[7*k +: 7] = seg_data[7*k +: 7];
`endif
    end

    assign w_restart = (r_state == IDLE);

    seg_shift_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (reset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_shift_nxt  = w_load;
                    w_bitcnt_nxt = c_last;
                    w_state_nxt  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (w_tick) begin
                    w_state_nxt = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (w_tick) begin
                    if (r_bitcnt == '0) begin
                        w_state_nxt = LATCH;
                    end else begin
                        w_shift_nxt  = {r_shift[c_bits-2:0], 1'b0};
                        w_bitcnt_nxt = r_bitcnt - c_one;
                        w_state_nxt  = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
        end
    end

    // Outputs are decoded from the next state and registered so the pins
    // driving the external chain never glitch on multi-bit state changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sdata <= 1'b0;
            r_latch <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
            r_sclk  <= (w_state_nxt == SHIFT_HI);
            r_latch <= (w_state_nxt == LATCH);
            r_sdata <= ((w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI))
                       ? w_shift_nxt[c_bits-1] : 1'b0;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sclk  = r_sclk;
    assign sdata = r_sdata;
    assign latch = r_latch;

endmodule

`default_nettype wire

// File: tb/tb_seg_shift_out.sv
// ============================================================================
// Module : tb_seg_shift_out
// Brief  : Self-checking bench for seg_shift_out (optionally SEG_SHIFT_DP_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_shift_out;

    localparam int ND = 6;
    localparam int D  = 2;
`ifdef SEG_SHIFT_DP_EN
    localparam int DW = 8;
`else
    localparam int DW = 7;
`endif
    localparam int B      = ND * DW;
    localparam int SW     = 7 * ND;
    localparam int T_DONE = 1 + 2 * D * B + D;

    typedef struct {
        logic [SW-1:0] seg;
        logic [ND-1:0] dp;
        int            change_at;
        logic [63:0]   exp_word;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [SW-1:0] seg_data;
    logic [ND-1:0] dp;
    logic          busy;
    logic          done;
    logic          sclk;
    logic          sdata;
    logic          latch;

    int            checks   = 0;
    int            failures = 0;
    int            m_t      = 0;
    logic [63:0]   m_w      = '0;

    always #5 clk = ~clk;

    seg_shift_out #(
        .NUM_DIGITS (ND),
        .CLK_DIV    (D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .seg_data (seg_data),
`ifdef SEG_SHIFT_DP_EN
        .dp       (dp),
`endif
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sclk     (sclk),
        .sdata    (sdata),
        .latch    (latch)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bit stream in wire order, first bit shifted held at position B-1.
    function automatic logic [63:0] model_word(input logic [SW-1:0] seg, input logic [ND-1:0] d);
        logic [63:0] w;
        w = '0;
        for (int k = ND - 1; k >= 0; k--) begin
            if (DW == 8) w = (w << 1) | 64'(d[k]);
            for (int s = 6; s >= 0; s--) w = (w << 1) | 64'(seg[7*k + s]);
        end
        return w;
    endfunction

    // Expected {busy,done,sclk,sdata,latch} in cycle t of a transfer (t>=1).
    function automatic logic [4:0] model_out(input int t, input logic [63:0] w);
        int shift_end;
        int i;
        logic hi;
        shift_end = 2 * D * B;
        if (t >= 1 && t <= shift_end) begin
            i  = (t - 1) / (2 * D);
            hi = (((t - 1) / D) % 2) == 1;
            return {1'b1, 1'b0, hi, w[B-1-i], 1'b0};
        end
        if (t > shift_end && t <= shift_end + D) return 5'b10001;
        if (t == shift_end + D + 1) return 5'b01000;
        return 5'b00000;
    endfunction

    task automatic cyc();
        logic [4:0] exp_o;
        @(posedge clk);
        if (reset) begin
            m_t = 0;
        end else if (m_t == 0 || m_t == T_DONE) begin
            if (start) begin
                m_t = 1;
                m_w = model_word(seg_data, dp);
            end else begin
                m_t = 0;
            end
        end else begin
            m_t = m_t + 1;
        end
        #1;
        exp_o = (m_t == 0) ? 5'b0 : model_out(m_t, m_w);
        check("outputs{busy,done,sclk,sdata,latch}", 64'({busy, done, sclk, sdata, latch}), 64'(exp_o));
    endtask

    task automatic xfer(input vec_t v, input string nm);
        int          t;
        int          rises;
        int          done_t;
        int          latch_n;
        logic [63:0] word;
        logic        prev;
        seg_data = v.seg;
        dp       = v.dp;
        start    = 1'b1;
        cyc();
        start   = 1'b0;
        t       = 1;
        rises   = 0;
        done_t  = -1;
        latch_n = 0;
        word    = '0;
        prev    = 1'b0;
        while (done_t < 0 && t <= T_DONE + 10) begin
            if (sclk && !prev) begin
                word = (word << 1) | 64'(sdata);
                rises++;
            end
            prev = sclk;
            if (latch) latch_n++;
            if (done) done_t = t;
            if (t == v.change_at) begin
                seg_data = '1;
                dp       = '1;
            end
            if (done_t < 0) begin
                cyc();
                t++;
            end
        end
        check({nm, " word"}, word, v.exp_word);
        check({nm, " sclk_rises"}, 64'(rises), 64'(B));
        check({nm, " done_cycle"}, 64'(done_t), 64'(T_DONE));
        check({nm, " latch_cycles"}, 64'(latch_n), 64'(D));
    endtask

    initial begin
        vec_t vecs[5];
        int   cnt;
        int   cnt2;
        logic prev_done;

        vecs[0] = '{seg: {ND{7'b1111110}}, dp: '0, change_at: 0, exp_word: '0};
        vecs[1] = '{seg: {ND{7'b1111110}}, dp: '0, change_at: 10, exp_word: '0};
        vecs[2] = '{seg: {ND{7'b1010101}}, dp: 6'b101010, change_at: 0, exp_word: '0};
        vecs[3] = '{seg: '0, dp: 6'b000100, change_at: 0, exp_word: '0};
        vecs[4] = '{seg: SW'({$urandom(), $urandom()}), dp: ND'($urandom()), change_at: 37, exp_word: '0};
        for (int i = 0; i < 5; i++) vecs[i].exp_word = model_word(vecs[i].seg, vecs[i].dp);

        reset    = 1'b1;
        start    = 1'b0;
        seg_data = '0;
        dp       = '0;
        repeat (3) cyc();
        reset = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (sclk) cnt++;
        end
        check("idle_sclk_high_count", 64'(cnt), 64'(0));

        for (int i = 0; i < 5; i++) xfer(vecs[i], $sformatf("vec%0d", i));

`ifdef SEG_SHIFT_DP_EN
        check("dp_digit2_only_bit24", vecs[3].exp_word, 64'(1) << (B - 1 - 24));
`endif

        // Reset in the middle of a transfer suppresses latch and done.
        seg_data = SW'({$urandom(), $urandom()});
        start    = 1'b1;
        cyc();
        start = 1'b0;
        repeat (49) cyc();
        reset = 1'b1;
        cyc();
        check("reset_mid_outputs", 64'({busy, done, sclk, sdata, latch}), 64'(0));
        reset = 1'b0;
        cnt   = 0;
        cnt2  = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (latch) cnt++;
            if (done) cnt2++;
        end
        check("reset_mid_latch_count", 64'(cnt), 64'(0));
        check("reset_mid_done_count", 64'(cnt2), 64'(0));
        xfer(vecs[2], "after_reset");

        // start held high: three back-to-back transfers.
        seg_data  = SW'({$urandom(), $urandom()});
        start     = 1'b1;
        cnt       = 0;
        cnt2      = 0;
        prev_done = 1'b0;
        for (int i = 1; i <= 3 * T_DONE + 5; i++) begin
            cyc();
            if (i == 3 * T_DONE) start = 1'b0;
            if (i == 30) seg_data = ~seg_data;
            if (prev_done && busy) cnt2++;
            if (done) cnt++;
            prev_done = done;
        end
        check("b2b_done_count", 64'(cnt), 64'(3));
        check("b2b_busy_after_done", 64'(cnt2), 64'(2));

        // Randomised traffic, every cycle compared to the reference.
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 999) == 0);
            seg_data = SW'({$urandom(), $urandom()});
            dp       = ND'($urandom());
            cyc();
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (T_DONE + 5) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
